// File: rtl/adder_sched_pkg.sv
// Shared types and helpers for the round-robin adder scheduler.
package adder_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } adder_sched_state_e;

  function automatic int rr_next(input int idx, input int num);
    int nxt;
    if (idx + 32'sd1 >= num) nxt = 32'sd0;
    else nxt = idx + 32'sd1;
    return nxt;
  endfunction

endpackage

// File: rtl/adder_rr_arb.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping.
module adder_rr_arb
  import adder_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_vec,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_any
);

  // One extra bit so ptr+i cannot overflow before the modulo fold.
  logic [IDX_W:0] cand_s;

  // Rotating priority scan starting at ptr.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    gnt_any    = 1'b0;
    cand_s     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_s = {1'b0, ptr} + (IDX_W+1)'(i);
      if (cand_s >= (IDX_W+1)'(NUM_REQ)) cand_s = cand_s - (IDX_W+1)'(NUM_REQ);
      else cand_s = cand_s;
      if (!gnt_any && req_vec[cand_s[IDX_W-1:0]]) begin
        gnt_any                         = 1'b1;
        gnt_onehot[cand_s[IDX_W-1:0]]   = 1'b1;
        gnt_idx                         = cand_s[IDX_W-1:0];
      end else begin
        gnt_any = gnt_any;
      end
    end
  end

endmodule

// File: rtl/adder_sched.sv
// Shares one registered adder between NUM_REQ requesters: round-robin accept,
// one-cycle add, then a held response until the granted requester takes it.
module adder_sched
  import adder_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                                main_clk_i,
  input  logic                                main_rst_i,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_a_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_b_i,
  output logic [NUM_REQ-1:0]                  rsp_valid_o,
  input  logic [NUM_REQ-1:0]                  rsp_ready_i,
  output logic [DATA_WIDTH:0]                 rsp_sum_o,
  output logic                                busy_o,
  output logic [$clog2(NUM_REQ)-1:0]          grant_id_o,
  output logic [CNT_WIDTH-1:0]                op_cnt_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int SUM_W = DATA_WIDTH + 1;
  localparam logic [NUM_REQ-1:0]   ONE_HOT_0 = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  adder_sched_state_e        state_r;
  logic [IDX_W-1:0]          ptr_r;
  logic [IDX_W-1:0]          grant_id_r;
  logic [DATA_WIDTH-1:0]     op_a_r;
  logic [DATA_WIDTH-1:0]     op_b_r;
  logic [SUM_W-1:0]          sum_r;
  logic [CNT_WIDTH-1:0]      op_cnt_r;
  logic [NUM_REQ-1:0]        rsp_valid_r;
  logic                      busy_r;
  logic [NUM_REQ-1:0]        arb_gnt_s;
  logic [IDX_W-1:0]          arb_idx_s;
  logic                      arb_any_s;
  logic [NUM_REQ-1:0]        req_ready_s;

  adder_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_vec    (req_valid_i),
    .ptr        (ptr_r),
    .gnt_onehot (arb_gnt_s),
    .gnt_idx    (arb_idx_s),
    .gnt_any    (arb_any_s)
  );

  // Accept is combinational in IDLE; suppressed while reset is held so nothing is taken.
  always_comb begin
    req_ready_s = '0;
    if (state_r == IDLE && !main_rst_i) req_ready_s = arb_gnt_s;
    else req_ready_s = '0;
  end

  // Scheduler FSM with the inline adder and all registered outputs.
  always_ff @(posedge main_clk_i or posedge main_rst_i) begin
    if (main_rst_i) begin
      state_r     <= IDLE;
      ptr_r       <= '0;
      grant_id_r  <= '0;
      op_a_r      <= '0;
      op_b_r      <= '0;
      sum_r       <= '0;
      op_cnt_r    <= '0;
      rsp_valid_r <= '0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (arb_any_s) begin
            op_a_r     <= req_a_i[arb_idx_s];
            op_b_r     <= req_b_i[arb_idx_s];
            grant_id_r <= arb_idx_s;
            busy_r     <= 1'b1;
            state_r    <= CALC;
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          sum_r       <= {1'b0, op_a_r} + {1'b0, op_b_r};
          rsp_valid_r <= ONE_HOT_0 << grant_id_r;
          state_r     <= RESP;
        end
        RESP: begin
          // Pointer advances only here, so a stalled response keeps its priority slot.
          if (rsp_ready_i[grant_id_r]) begin
            rsp_valid_r <= '0;
            busy_r      <= 1'b0;
            op_cnt_r    <= op_cnt_r + CNT_ONE;
            ptr_r       <= IDX_W'(rr_next(32'(grant_id_r), NUM_REQ));
            state_r     <= IDLE;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          rsp_valid_r <= '0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready_o = req_ready_s;
  assign rsp_valid_o = rsp_valid_r;
  assign rsp_sum_o   = sum_r;
  assign busy_o      = busy_r;
  assign grant_id_o  = grant_id_r;
  assign op_cnt_o    = op_cnt_r;

endmodule
